// File: rtl/mux_oehb_pkg.sv
// -----------------------------------------------------------------------------
// mux_oehb_pkg
//   Shared types and helpers for the mux_oehb select/join stage.
//   - join_e        : per-cycle classification of the index/data join.
//   - sel_width_ok  : checks that a SELECT_TYPE-wide index can address SIZE
//                     channels (2^SELECT_TYPE >= SIZE).
//   - chan_lsb      : LSB position of channel i in a flattened data bus.
// -----------------------------------------------------------------------------
package mux_oehb_pkg;

   // What the join does this cycle:
   //   JOIN_IDLE : no index token offered
   //   JOIN_WAIT : index offered, but data or output slot not available,
   //               or the index is out of range and must stall
   //   JOIN_FIRE : index and selected data both consumed into the buffer
   //   JOIN_DROP : out-of-range index consumed without producing data
   typedef enum logic [1:0] {
      JOIN_IDLE = 2'd0,
      JOIN_WAIT = 2'd1,
      JOIN_FIRE = 2'd2,
      JOIN_DROP = 2'd3
   } join_e;

   function automatic bit sel_width_ok(input int unsigned size,
                                       input int unsigned sel_w);
      if (sel_w >= 32) return 1'b1;
      return (64'd1 << sel_w) >= 64'(size);
   endfunction

   function automatic int unsigned chan_lsb(input int unsigned chan,
                                            input int unsigned width);
      return chan * width;
   endfunction

endpackage

// File: rtl/mux_oehb_oehb.sv
// -----------------------------------------------------------------------------
// oehb
//   Generic one-slot registered output buffer (opaque elastic half buffer).
//   Accepts a token whenever the slot is empty or being drained in the same
//   cycle, so a continuously ready consumer sees full throughput.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset (slot emptied, data 0)
//     ins        in   DATA_TYPE  incoming data
//     ins_valid  in   incoming valid
//     ins_ready  out  slot can accept (forced 0 during reset)
//     outs       out  DATA_TYPE  registered data
//     outs_valid out  registered valid
//     outs_ready in   downstream ready
// -----------------------------------------------------------------------------
module oehb #(
   parameter int unsigned DATA_TYPE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] ins,
   input  logic                 ins_valid,
   output logic                 ins_ready,
   output logic [DATA_TYPE-1:0] outs,
   output logic                 outs_valid,
   input  logic                 outs_ready
);

   logic                 r_valid;
   logic [DATA_TYPE-1:0] r_data;
   logic                 w_load;

   // Ready depends only on the registered valid and downstream ready, never
   // on ins_valid, so upstream join logic can use it without a loop.
   assign ins_ready = !rst && (!r_valid || outs_ready);
   assign w_load    = ins_valid && ins_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_data  <= ins;
      end else if (outs_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign outs       = r_data;
   assign outs_valid = r_valid;

endmodule

// File: rtl/mux_oehb.sv
// -----------------------------------------------------------------------------
// mux_oehb
//   Data multiplexer steered by an index token (from an upstream control
//   merge). One index token is joined with one token from the selected data
//   channel and forwarded through a one-slot registered buffer, which cuts the
//   combinational valid/data path to downstream logic at full throughput.
//
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   synchronous active-high reset
//     ins          in   SIZE*DATA_TYPE flattened data, channel i at
//                       [i*DATA_TYPE +: DATA_TYPE]
//     ins_valid    in   SIZE per-channel valid
//     ins_ready    out  SIZE per-channel ready (only the selected one fires)
//     index        in   SELECT_TYPE select token
//     index_valid  in   select valid
//     index_ready  out  select ready
//     outs         out  DATA_TYPE registered data
//     outs_valid   out  registered valid
//     outs_ready   in   downstream ready
//     index_error  out  (MUX_OOR_CHECK_EN only) sticky flag, set when an
//                       out-of-range index is consumed, cleared by rst
//
//   Build option:
//     MUX_OOR_CHECK_EN  when defined, an out-of-range index is consumed and
//                       flagged instead of stalling forever.
// -----------------------------------------------------------------------------
module mux_oehb
   import mux_oehb_pkg::*;
#(
   parameter int unsigned SIZE        = 2,
   parameter int unsigned DATA_TYPE   = 32,
   parameter int unsigned SELECT_TYPE = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SIZE*DATA_TYPE-1:0] ins,
   input  logic [SIZE-1:0]           ins_valid,
   output logic [SIZE-1:0]           ins_ready,
   input  logic [SELECT_TYPE-1:0]    index,
   input  logic                      index_valid,
   output logic                      index_ready,
   output logic [DATA_TYPE-1:0]      outs,
   output logic                      outs_valid,
`ifdef MUX_OOR_CHECK_EN
   output logic                      index_error,
`endif
   input  logic                      outs_ready
);

   generate
      if (SIZE < 2 || !sel_width_ok(SIZE, SELECT_TYPE)) begin : g_bad_cfg
         $error("mux_oehb: SIZE must be >= 2 and 2**SELECT_TYPE >= SIZE");
      end
   endgenerate

   logic [31:0]          w_idx32;
   logic                 w_in_range;
   logic [DATA_TYPE-1:0] w_sel_data;
   logic                 w_sel_valid;
   logic                 w_slot_ready;
   join_e                w_join;

   assign w_idx32    = 32'(index);
   assign w_in_range = (w_idx32 < SIZE);

   // Channel select by comparison rather than a variable part-select, so an
   // out-of-range index simply selects nothing instead of slicing past ins.
   always_comb begin
      w_sel_data  = '0;
      w_sel_valid = 1'b0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         if (w_idx32 == 32'(i)) begin
            w_sel_data  = ins[chan_lsb(i, DATA_TYPE) +: DATA_TYPE];
            w_sel_valid = ins_valid[i];
         end
      end
   end

   always_comb begin
      w_join = JOIN_IDLE;
      if (!rst && index_valid) begin
         if (!w_in_range) begin
`ifdef MUX_OOR_CHECK_EN
            w_join = JOIN_DROP;
`else
            w_join = JOIN_WAIT;
`endif
         end else if (w_sel_valid && w_slot_ready) begin
            w_join = JOIN_FIRE;
         end else begin
            w_join = JOIN_WAIT;
         end
      end
   end

   assign index_ready = (w_join == JOIN_FIRE) || (w_join == JOIN_DROP);

   always_comb begin
      ins_ready = '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         ins_ready[i] = (w_join == JOIN_FIRE) && (w_idx32 == 32'(i));
      end
   end

   oehb #(
      .DATA_TYPE (DATA_TYPE)
   ) u_oehb (
      .clk        (clk),
      .rst        (rst),
      .ins        (w_sel_data),
      .ins_valid  (w_join == JOIN_FIRE),
      .ins_ready  (w_slot_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready)
   );

`ifdef MUX_OOR_CHECK_EN
   logic r_index_error;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_index_error <= 1'b0;
      end else if (w_join == JOIN_DROP) begin
         r_index_error <= 1'b1;
      end
   end

   assign index_error = r_index_error;
`endif

endmodule

// File: tb/tb_mux_oehb.sv
// -----------------------------------------------------------------------------
// tb_mux_oehb
//   Bench for mux_oehb with SIZE=3, DATA_TYPE=8, SELECT_TYPE=2. A queue-based
//   model of the one-slot output stage predicts outputs and readies each
//   cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_mux_oehb;

   localparam int unsigned SIZE = 3;
   localparam int unsigned DW   = 8;
   localparam int unsigned SW   = 2;
`ifdef MUX_OOR_CHECK_EN
   localparam bit OOR_EN = 1'b1;
`else
   localparam bit OOR_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [SIZE*DW-1:0] ins;
   logic [SIZE-1:0]    ins_valid;
   logic [SIZE-1:0]    ins_ready;
   logic [SW-1:0]      index;
   logic               index_valid;
   logic               index_ready;
   logic [DW-1:0]      outs;
   logic               outs_valid;
   logic               outs_ready;
   logic               index_error;

   int total = 0;
   int bad   = 0;

   mux_oehb #(
      .SIZE        (SIZE),
      .DATA_TYPE   (DW),
      .SELECT_TYPE (SW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ins         (ins),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .index       (index),
      .index_valid (index_valid),
      .index_ready (index_ready),
      .outs        (outs),
      .outs_valid  (outs_valid),
`ifdef MUX_OOR_CHECK_EN
      .index_error (index_error),
`endif
      .outs_ready  (outs_ready)
   );

`ifndef MUX_OOR_CHECK_EN
   assign index_error = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] q[$];        // tokens held in the output slot
   logic [DW-1:0] m_last = '0; // value outs shows (holds after drain)
   bit            m_err  = 1'b0;
   bit            started = 1'b0;

   function automatic logic [DW-1:0] chan(input int c);
      return ins[c*DW +: DW];
   endfunction

   always @(negedge clk) begin
      bit            inr;
      bit            fire;
      bit            drop;
      logic [SIZE-1:0] exp_ir;
      inr  = (int'(index) < SIZE);
      fire = !rst && index_valid && inr && ins_valid[int'(index) % SIZE]
             && (q.size() == 0 || outs_ready);
      drop = OOR_EN && !rst && index_valid && !inr;
      exp_ir = fire ? SIZE'(1 << index) : '0;
      check("ins_ready", 32'(ins_ready), 32'(exp_ir));
      check("index_ready", 32'(index_ready), 32'(fire || drop));
      if (started) begin
         check("outs_valid", 32'(outs_valid), 32'(q.size() != 0));
         check("outs", 32'(outs), 32'(m_last));
         if (OOR_EN) check("index_error", 32'(index_error), 32'(m_err));
      end
      if (rst) begin
         q.delete();
         m_last  = '0;
         m_err   = 1'b0;
         started = 1'b1;
      end else begin
         if (outs_ready && q.size() != 0) void'(q.pop_front());
         if (fire) begin
            q.push_back(chan(int'(index)));
            m_last = chan(int'(index));
         end
         if (drop) m_err = 1'b1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_chan(input int c, input logic [DW-1:0] v);
      ins[c*DW +: DW] = v;
   endtask

   task automatic idle_inputs();
      ins_valid   = '0;
      index_valid = 1'b0;
      index       = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ins = '0; outs_ready = 1'b1;
      idle_inputs();
      repeat (3) step();
      check("rst_outs_valid", 32'(outs_valid), 32'd0);
      check("rst_outs", 32'(outs), 32'd0);
      rst = 1'b0;
      step();

      // Single token: channel 1 selected, channel 0 left pending
      set_chan(0, 8'h3C); set_chan(1, 8'hA5);
      ins_valid = 3'b011; index = 2'd1; index_valid = 1'b1;
      #1;
      check("single_ins_ready", 32'(ins_ready), 32'h2);
      check("single_index_ready", 32'(index_ready), 32'd1);
      step();
      index_valid = 1'b0; ins_valid = 3'b001;
      #1;
      check("single_outs", 32'(outs), 32'hA5);
      check("single_outs_valid", 32'(outs_valid), 32'd1);
      check("single_ch0_pending", 32'(ins_ready), 32'd0);
      step();
      idle_inputs();

      // Back-pressure
      set_chan(0, 8'h11); ins_valid = 3'b001; index = 2'd0; index_valid = 1'b1;
      outs_ready = 1'b0;
      step();
      set_chan(0, 8'h22);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_outs", 32'(outs), 32'h11);
         check("bp_index_ready", 32'(index_ready), 32'd0);
         check("bp_ins_ready", 32'(ins_ready), 32'd0);
         step();
      end
      outs_ready = 1'b1;
      step();
      idle_inputs();
      #1;
      check("bp_after", 32'(outs), 32'h22);
      step();

      // Streaming, alternating channels, no bubbles
      for (int k = 0; k < 4; k++) begin
         index = SW'(k % 2); index_valid = 1'b1; ins_valid = 3'b011;
         set_chan(k % 2, DW'(k + 1));
         step();
         #1;
         check("stream_outs", 32'(outs), 32'(k + 1));
         check("stream_valid", 32'(outs_valid), 32'd1);
      end
      idle_inputs();
      step();

      // Late data
      index = 2'd1; index_valid = 1'b1; set_chan(1, 8'h7E);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("late_index_ready", 32'(index_ready), 32'd0);
         step();
      end
      ins_valid = 3'b010;
      #1;
      check("late_fire", 32'(index_ready), 32'd1);
      step();
      idle_inputs();
      #1;
      check("late_outs", 32'(outs), 32'h7E);
      check("late_valid", 32'(outs_valid), 32'd1);
      step();

      // Reset mid-operation
      outs_ready = 1'b0;
      set_chan(2, 8'h55); ins_valid = 3'b100; index = 2'd2; index_valid = 1'b1;
      step();
      rst = 1'b1;
      #1;
      check("midrst_index_ready", 32'(index_ready), 32'd0);
      check("midrst_ins_ready", 32'(ins_ready), 32'd0);
      step();
      check("midrst_valid", 32'(outs_valid), 32'd0);
      check("midrst_outs", 32'(outs), 32'd0);
      rst = 1'b0;
      idle_inputs();
      step();

      // Out-of-range index with a token buffered and stalled
      set_chan(0, 8'h66); ins_valid = 3'b001; index = 2'd0; index_valid = 1'b1;
      step();
      ins_valid = 3'b111; index = 2'd3;
      #1;
      check("oor_index_ready", 32'(index_ready), 32'(OOR_EN));
      check("oor_ins_ready", 32'(ins_ready), 32'd0);
      step();
      if (OOR_EN) index_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("oor_error", 32'(index_error), 32'(OOR_EN));
         check("oor_outs_valid", 32'(outs_valid), 32'd1);
         check("oor_outs", 32'(outs), 32'h66);
         if (!OOR_EN) check("oor_stall", 32'(index_ready), 32'd0);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_inputs();
      #1;
      check("oor_err_cleared", 32'(index_error), 32'd0);
      step();

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(0, 63) == 0);
         index       = SW'($urandom_range(0, 3));
         index_valid = ($urandom_range(0, 3) != 0);
         ins_valid   = SIZE'($urandom);
         ins         = (SIZE*DW)'($urandom);
         outs_ready  = ($urandom_range(0, 3) != 0);
         step();
      end
      rst = 1'b0;
      idle_inputs();
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
